// File: rtl/tow_pkg.sv
// Shared types for the tug-of-war match controller: round state encoding and player codes.
package tow_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      COUNTDOWN = 3'd1,
      PLAY      = 3'd2,
      ROUND_END = 3'd3,
      MATCH_END = 3'd4
   } tow_state_e;

   localparam logic [1:0] TOW_NONE = 2'd0;
   localparam logic [1:0] TOW_P1   = 2'd1;
   localparam logic [1:0] TOW_P2   = 2'd2;

endpackage

// File: rtl/tow_tick_timer.sv
// Free-running step timer: expire pulses for one cycle when the count reaches COUNT_CYCLES-1.
module tow_tick_timer #(
   parameter int COUNT_CYCLES = 25_000_000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   output logic expire
);

   localparam int CW = (COUNT_CYCLES > 1) ? $clog2(COUNT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(COUNT_CYCLES - 1);

   logic [CW-1:0] count;

   // expire looks only at the register so the controller can derive clear from it without a loop
   assign expire = (count == LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         count <= '0;
      else if (clear || expire)
         count <= '0;
      else
         count <= count + CW'(1);
   end

endmodule

// File: rtl/tow_match_ctrl.sv
// Tug-of-war match controller: round sequencing, rope position and scoring.
// Define TOW_FALSE_START_EN to penalise presses made during the countdown.
module tow_match_ctrl
   import tow_pkg::*;
#(
   parameter int FIELD_HALF    = 4,
   parameter int ROUNDS_TO_WIN = 3,
   parameter int COUNT_CYCLES  = 25_000_000,
   localparam int PW = $clog2(FIELD_HALF + 1) + 1,
   localparam int SW = $clog2(ROUNDS_TO_WIN + 1),
   localparam int LW = 2 * FIELD_HALF + 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic                 press1,
   input  logic                 press2,
   output logic signed [PW-1:0] pos,
   output logic [LW-1:0]        rope_leds,
   output logic [1:0]           countdown,
   output tow_state_e           state,
   output logic [SW-1:0]        score1,
   output logic [SW-1:0]        score2,
   output logic [1:0]           round_winner,
   output logic [1:0]           match_winner
);

   localparam logic signed [PW-1:0] POS_HI = PW'(FIELD_HALF);
   localparam logic signed [PW-1:0] POS_LO = PW'(-FIELD_HALF);
   localparam logic signed [PW-1:0] ONE    = PW'(1);
   localparam logic [SW-1:0]        SCORE_MAX = SW'(ROUNDS_TO_WIN);
`ifdef TOW_FALSE_START_EN
   localparam logic signed [PW-1:0] FS_HI = PW'(FIELD_HALF - 1);
   localparam logic signed [PW-1:0] FS_LO = PW'(1 - FIELD_HALF);
`endif

   tow_state_e             state_n;
   logic signed [PW-1:0]   pos_n;
   logic signed [PW-1:0]   pos_mv;
   logic [LW-1:0]          leds_n;
   logic [1:0]             countdown_n;
   logic [SW-1:0]          score1_n;
   logic [SW-1:0]          score2_n;
   logic [1:0]             round_winner_n;
   logic [1:0]             match_winner_n;
   logic                   clear;
   logic                   expire;

   // Timer restarts on every state entry and idles at 0 where no timing is needed
   assign clear = (state_n != state) || (state == IDLE) || (state == PLAY) || (state == MATCH_END);

   tow_tick_timer #(.COUNT_CYCLES(COUNT_CYCLES)) u_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (clear),
      .expire  (expire)
   );

   always_comb begin
      state_n        = state;
      pos_n          = pos;
      pos_mv         = pos;
      countdown_n    = countdown;
      score1_n       = score1;
      score2_n       = score2;
      round_winner_n = round_winner;
      match_winner_n = match_winner;
      case (state)
         IDLE: begin
            if (start) begin
               state_n     = COUNTDOWN;
               countdown_n = 2'd3;
            end
         end
         COUNTDOWN: begin
`ifdef TOW_FALSE_START_EN
            // Penalty pushes against the offender but never reaches a win line
            if (press1 && !press2 && (pos > FS_LO))
               pos_n = pos - ONE;
            else if (press2 && !press1 && (pos < FS_HI))
               pos_n = pos + ONE;
`endif
            if (expire) begin
               if (countdown == 2'd1) begin
                  state_n     = PLAY;
                  countdown_n = 2'd0;
               end else begin
                  countdown_n = countdown - 2'd1;
               end
            end
         end
         PLAY: begin
            if (press1 && !press2)
               pos_mv = pos + ONE;
            else if (press2 && !press1)
               pos_mv = pos - ONE;
            pos_n = pos_mv;
            if (pos_mv == POS_HI) begin
               state_n        = ROUND_END;
               round_winner_n = TOW_P1;
               score1_n       = (score1 == SCORE_MAX) ? score1 : score1 + SW'(1);
            end else if (pos_mv == POS_LO) begin
               state_n        = ROUND_END;
               round_winner_n = TOW_P2;
               score2_n       = (score2 == SCORE_MAX) ? score2 : score2 + SW'(1);
            end
         end
         ROUND_END: begin
            if (expire) begin
               if (((round_winner == TOW_P1) && (score1 == SCORE_MAX)) ||
                   ((round_winner == TOW_P2) && (score2 == SCORE_MAX))) begin
                  state_n        = MATCH_END;
                  match_winner_n = round_winner;
               end else begin
                  state_n     = COUNTDOWN;
                  pos_n       = '0;
                  countdown_n = 2'd3;
               end
            end
         end
         MATCH_END: begin
            if (start) begin
               state_n        = COUNTDOWN;
               countdown_n    = 2'd3;
               pos_n          = '0;
               score1_n       = '0;
               score2_n       = '0;
               round_winner_n = TOW_NONE;
               match_winner_n = TOW_NONE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      leds_n = '0;
      for (int i = 0; i < LW; i++)
         if (pos_n == PW'(i - FIELD_HALF))
            leds_n[i] = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         pos          <= '0;
         rope_leds    <= LW'(1) << FIELD_HALF;
         countdown    <= 2'd0;
         score1       <= '0;
         score2       <= '0;
         round_winner <= TOW_NONE;
         match_winner <= TOW_NONE;
      end else begin
         state        <= state_n;
         pos          <= pos_n;
         rope_leds    <= leds_n;
         countdown    <= countdown_n;
         score1       <= score1_n;
         score2       <= score2_n;
         round_winner <= round_winner_n;
         match_winner <= match_winner_n;
      end
   end

endmodule

// File: tb/tb_tow_match_ctrl.sv
// Directed bench for tow_match_ctrl; expectations for countdown presses follow TOW_FALSE_START_EN.
module tb_tow_match_ctrl;
   import tow_pkg::*;

   localparam int FH = 4;
   localparam int RTW = 2;
   localparam int CC = 4;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              start, press1, press2;
   logic signed [3:0] pos;
   logic [8:0]        rope_leds;
   logic [1:0]        countdown;
   tow_state_e        state;
   logic [1:0]        score1, score2;
   logic [1:0]        round_winner, match_winner;

   int vec_cnt = 0;
   int err_cnt = 0;
   int exp_fs;

   tow_match_ctrl #(.FIELD_HALF(FH), .ROUNDS_TO_WIN(RTW), .COUNT_CYCLES(CC)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (start),
      .press1       (press1),
      .press2       (press2),
      .pos          (pos),
      .rope_leds    (rope_leds),
      .countdown    (countdown),
      .state        (state),
      .score1       (score1),
      .score2       (score2),
      .round_winner (round_winner),
      .match_winner (match_winner)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input int got, input int exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic pulse(input logic s, input logic p1, input logic p2);
      start = s; press1 = p1; press2 = p2;
      @(posedge clk);
      #1;
      start = 1'b0; press1 = 1'b0; press2 = 1'b0;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_state"}, int'(state), int'(IDLE));
      check({tag, "_pos"}, pos, 0);
      check({tag, "_leds"}, rope_leds, 9'b000010000);
      check({tag, "_cd"}, countdown, 0);
      check({tag, "_s1"}, score1, 0);
      check({tag, "_s2"}, score2, 0);
      check({tag, "_rw"}, round_winner, 0);
      check({tag, "_mw"}, match_winner, 0);
   endtask

   initial begin
`ifdef TOW_FALSE_START_EN
      exp_fs = -3;
`else
      exp_fs = 0;
`endif
      reset_n = 1'b0; start = 1'b0; press1 = 1'b0; press2 = 1'b0;
      wait_cycles(2);
      check_reset_values("rst");
      reset_n = 1'b1;

      // presses in IDLE do nothing
      pulse(0, 1, 0);
      check("idle_press_pos", pos, 0);
      check("idle_press_state", int'(state), int'(IDLE));

      // round 1: countdown timing then player 1 wins
      pulse(1, 0, 0);
      check("cd_state", int'(state), int'(COUNTDOWN));
      check("cd_3", countdown, 3);
      wait_cycles(4);
      check("cd_2", countdown, 2);
      wait_cycles(4);
      check("cd_1", countdown, 1);
      wait_cycles(3);
      check("cd_not_yet_play", int'(state), int'(COUNTDOWN));
      wait_cycles(1);
      check("play_entry", int'(state), int'(PLAY));
      check("play_pos", pos, 0);
      check("play_leds", rope_leds, 9'b000010000);
      check("play_cd", countdown, 0);
      for (int i = 0; i < 3; i++) pulse(0, 1, 0);
      check("p1_pos3", pos, 3);
      check("p1_state_play", int'(state), int'(PLAY));
      pulse(0, 1, 0);
      check("r1_pos", pos, 4);
      check("r1_state", int'(state), int'(ROUND_END));
      check("r1_s1", score1, 1);
      check("r1_rw", round_winner, 1);
      check("r1_leds", rope_leds, 9'b100000000);
      pulse(0, 0, 1);
      wait_cycles(2);
      check("r1_hold_state", int'(state), int'(ROUND_END));
      check("r1_hold_pos", pos, 4);
      wait_cycles(1);
      check("r1_to_cd", int'(state), int'(COUNTDOWN));
      check("r1_to_cd_pos", pos, 0);
      check("r1_to_cd_cd", countdown, 3);

      // round 2: ties cancel, then player 2 wins
      wait_cycles(12);
      check("r2_play", int'(state), int'(PLAY));
      for (int i = 0; i < 3; i++) pulse(0, 1, 1);
      check("tie_pos", pos, 0);
      pulse(0, 0, 1);
      check("p2_pos", pos, -1);
      check("p2_leds", rope_leds, 9'b000001000);
      for (int i = 0; i < 3; i++) pulse(0, 0, 1);
      check("r2_state", int'(state), int'(ROUND_END));
      check("r2_pos", pos, -4);
      check("r2_leds", rope_leds, 9'b000000001);
      check("r2_s2", score2, 1);
      check("r2_rw", round_winner, 2);
      wait_cycles(4);
      check("r2_to_cd", int'(state), int'(COUNTDOWN));

      // round 3: countdown presses, start ignored, player 2 takes the match
      for (int i = 0; i < 5; i++) pulse(0, 1, 0);
      check("fs_pos", pos, exp_fs);
      pulse(1, 0, 0);
      check("cd_start_ignored", int'(state), int'(COUNTDOWN));
      check("cd_start_cd", countdown, 2);
      wait_cycles(6);
      check("r3_play", int'(state), int'(PLAY));
      check("r3_play_pos", pos, exp_fs);
      for (int i = 0; i < exp_fs + 4; i++) pulse(0, 0, 1);
      check("r3_state", int'(state), int'(ROUND_END));
      check("r3_s2", score2, 2);
      check("r3_s1", score1, 1);
      check("r3_mw_early", match_winner, 0);
      wait_cycles(3);
      check("r3_hold", int'(state), int'(ROUND_END));
      wait_cycles(1);
      check("match_state", int'(state), int'(MATCH_END));
      check("match_mw", match_winner, 2);
      check("match_pos", pos, -4);
      pulse(0, 1, 0);
      pulse(0, 0, 1);
      check("match_press_pos", pos, -4);
      check("match_press_state", int'(state), int'(MATCH_END));
      pulse(1, 0, 0);
      check("restart_state", int'(state), int'(COUNTDOWN));
      check("restart_s1", score1, 0);
      check("restart_s2", score2, 0);
      check("restart_rw", round_winner, 0);
      check("restart_mw", match_winner, 0);
      check("restart_pos", pos, 0);
      check("restart_cd", countdown, 3);

      // new match: reach pos 2 with score1=1, then async reset
      wait_cycles(12);
      for (int i = 0; i < 4; i++) pulse(0, 1, 0);
      check("m2_r1_s1", score1, 1);
      wait_cycles(4);
      wait_cycles(12);
      check("m2_play", int'(state), int'(PLAY));
      pulse(0, 1, 0);
      pulse(0, 1, 0);
      check("m2_pos2", pos, 2);
      reset_n = 1'b0;
      #1;
      check_reset_values("async");
      wait_cycles(1);
      reset_n = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
